// File: rtl/wor_array_serializer.sv
// Captures one masked snapshot of a ROWS x COLS array and streams the selected elements,
// lowest flat index first, over a valid/ready port with an XOR checksum per frame.
module wor_array_serializer #(
    parameter int unsigned ELEM_W = 48,
    parameter int unsigned ROWS   = 5,
    parameter int unsigned COLS   = 2,
    localparam int unsigned N     = ROWS * COLS,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*ELEM_W-1:0]   in_data,
    input  logic [N-1:0]          in_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ELEM_W-1:0]     out_data,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,
    output logic                  frame_done,
    output logic [ELEM_W-1:0]     frame_csum
);

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    state_e              state_q, state_d;
    logic [N*ELEM_W-1:0] data_q;
    logic [N-1:0]        mask_q;
    logic [ELEM_W-1:0]   acc_q;
    logic [ELEM_W-1:0]   csum_q;

    logic [IDX_W-1:0]    sel_idx;
    logic [N-1:0]        sel_onehot;
    logic [ELEM_W-1:0]   sel_elem;
    logic                sel_only;

    // Priority encoder: lowest remaining mask bit wins.
    always_comb begin
        sel_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (mask_q[k]) sel_idx = IDX_W'(k);
        end
    end

    assign sel_onehot = N'(1) << sel_idx;
    assign sel_elem   = data_q[sel_idx*ELEM_W +: ELEM_W];
    assign sel_only   = (mask_q & (mask_q - N'(1))) == '0;
    assign frame_csum = csum_q;

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_idx    = '0;
        out_last   = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = (in_mask == '0) ? StDone : StSend;
            end
            StSend: begin
                out_valid = 1'b1;
                out_data  = sel_elem;
                out_idx   = sel_idx;
                out_last  = sel_only;
                if (out_ready && sel_only) state_d = StDone;
            end
            StDone: begin
                frame_done = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            mask_q  <= '0;
            acc_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && in_valid) begin
                data_q <= in_data;
                mask_q <= in_mask;
                acc_q  <= '0;
                if (in_mask == '0) csum_q <= '0;
            end else if (state_q == StSend && out_ready) begin
                mask_q <= mask_q & ~sel_onehot;
                acc_q  <= acc_q ^ sel_elem;
                // Publish on the last beat so frame_csum is ready during DONE.
                if (sel_only) csum_q <= acc_q ^ sel_elem;
            end
        end
    end

endmodule

// File: tb/tb_wor_array_serializer.sv
// Randomized self-checking bench for wor_array_serializer against a queue-based model
// of the masked, ascending-index element stream and its XOR checksum.
module tb_wor_array_serializer;

    localparam int ELEM_W = 48;
    localparam int N      = 10;
    localparam int IDX_W  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [N*ELEM_W-1:0] in_data;
    logic [N-1:0]        in_mask;
    logic                out_valid;
    logic                out_ready;
    logic [ELEM_W-1:0]   out_data;
    logic [IDX_W-1:0]    out_idx;
    logic                out_last;
    logic                frame_done;
    logic [ELEM_W-1:0]   frame_csum;

    wor_array_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mask    (in_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .frame_done (frame_done),
        .frame_csum (frame_csum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int                exp_idx[$];
    logic [ELEM_W-1:0] exp_data[$];
    logic [ELEM_W-1:0] exp_csum;
    int                obs_idx[$];
    logic [ELEM_W-1:0] obs_data[$];
    logic              obs_last[$];
    logic [ELEM_W-1:0] done_csum;
    int                done_cyc;
    int                unstable;
    int                busy_ready;
    bit                got_done;

    // Reference: selected elements in ascending k, checksum is their XOR.
    function automatic void model(input logic [N*ELEM_W-1:0] d, input logic [N-1:0] m);
        exp_idx.delete();
        exp_data.delete();
        exp_csum = '0;
        for (int k = 0; k < N; k++) begin
            if (m[k]) begin
                exp_idx.push_back(k);
                exp_data.push_back(d[k*ELEM_W +: ELEM_W]);
                exp_csum ^= d[k*ELEM_W +: ELEM_W];
            end
        end
    endfunction

    function automatic logic [N*ELEM_W-1:0] rand_data();
        logic [N*ELEM_W-1:0] r;
        logic [63:0]         t;
        for (int k = 0; k < N; k++) begin
            t = {$urandom(), $urandom()};
            r[k*ELEM_W +: ELEM_W] = t[ELEM_W-1:0];
        end
        return r;
    endfunction

    task automatic send_snapshot(input logic [N*ELEM_W-1:0] d, input logic [N-1:0] m);
        int w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = m;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%0b want 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // mode 0: ready always high, 1: toggling starting high, 2: random
    task automatic collect(input int mode);
        logic [ELEM_W-1:0] pd;
        int                pi;
        logic              pl;
        bit                have_prev = 0;
        obs_idx.delete();
        obs_data.delete();
        obs_last.delete();
        got_done   = 0;
        done_cyc   = -1;
        done_csum  = '0;
        unstable   = 0;
        busy_ready = 0;
        pd = '0;
        pi = 0;
        pl = 1'b0;
        for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
            @(negedge clk);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (have_prev && (!out_valid || out_data !== pd || int'(out_idx) != pi
                              || out_last !== pl)) unstable++;
            have_prev = 0;
            if ((out_valid || frame_done) && in_ready) busy_ready++;
            if (out_valid && !out_ready) begin
                have_prev = 1;
                pd = out_data;
                pi = int'(out_idx);
                pl = out_last;
            end
            if (out_valid && out_ready) begin
                obs_idx.push_back(int'(out_idx));
                obs_data.push_back(out_data);
                obs_last.push_back(out_last);
            end
            if (frame_done) begin
                got_done  = 1;
                done_cyc  = cyc;
                done_csum = frame_csum;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_mask = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || out_idx !== '0) begin
            errors++;
            $display("FAIL reset_out got valid %0b last %0b data %h idx %0d want 0", out_valid,
                     out_last, out_data, out_idx);
        end
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_frame_done got %0b want 0", frame_done);
        end
        checks++;
        if (frame_csum !== '0) begin
            errors++; $display("FAIL reset_csum got %h want 0", frame_csum);
        end
    endtask

    task automatic test_full_mask();
        logic [N*ELEM_W-1:0] d;
        for (int k = 0; k < N; k++) d[k*ELEM_W +: ELEM_W] = 48'h1000_0000_0000 + 48'(k);
        model(d, 10'h3FF);
        send_snapshot(d, 10'h3FF);
        collect(0);
        checks++;
        if (obs_idx.size() != exp_idx.size()) begin
            errors++; $display("FAIL full_beats got %0d want %0d", obs_idx.size(), exp_idx.size());
        end
        foreach (exp_idx[i]) begin
            if (i < obs_idx.size()) begin
                checks++;
                if (obs_idx[i] != exp_idx[i] || obs_data[i] !== exp_data[i]
                    || obs_last[i] !== (i == exp_idx.size() - 1)) begin
                    errors++;
                    $display("FAIL full_beat%0d got idx %0d data %h last %0b want idx %0d data %h",
                             i, obs_idx[i], obs_data[i], obs_last[i], exp_idx[i], exp_data[i]);
                end
            end
        end
        checks++;
        if (done_cyc != 10) begin
            errors++; $display("FAIL full_done_cycle got %0d want 10", done_cyc);
        end
        checks++;
        if (done_csum !== 48'h0000_0000_0001 || done_csum !== exp_csum) begin
            errors++; $display("FAIL full_csum got %h want %h", done_csum, 48'h1);
        end
        checks++;
        if (unstable != 0 || busy_ready != 0) begin
            errors++; $display("FAIL full_handshake got unstable %0d busy_ready %0d want 0 0",
                               unstable, busy_ready);
        end
    endtask

    task automatic test_sparse_stall();
        logic [N*ELEM_W-1:0] d = rand_data();
        model(d, 10'b10_0000_0101);
        send_snapshot(d, 10'b10_0000_0101);
        collect(1);
        checks++;
        if (obs_idx.size() != 3) begin
            errors++; $display("FAIL sparse_beats got %0d want 3", obs_idx.size());
        end
        foreach (exp_idx[i]) begin
            if (i < obs_idx.size()) begin
                checks++;
                if (obs_idx[i] != exp_idx[i] || obs_data[i] !== exp_data[i]
                    || obs_last[i] !== (i == exp_idx.size() - 1)) begin
                    errors++;
                    $display("FAIL sparse_beat%0d got idx %0d data %h last %0b want idx %0d data %h",
                             i, obs_idx[i], obs_data[i], obs_last[i], exp_idx[i], exp_data[i]);
                end
            end
        end
        checks++;
        if (!got_done || done_csum !== exp_csum) begin
            errors++; $display("FAIL sparse_csum got done %0b csum %h want %h", got_done,
                               done_csum, exp_csum);
        end
        checks++;
        if (unstable != 0 || busy_ready != 0) begin
            errors++; $display("FAIL sparse_stall_stable got unstable %0d busy_ready %0d want 0 0",
                               unstable, busy_ready);
        end
    endtask

    task automatic test_empty_mask();
        send_snapshot(rand_data(), '0);
        collect(0);
        checks++;
        if (obs_idx.size() != 0 || done_cyc != 0) begin
            errors++; $display("FAIL empty_frame got beats %0d done_cycle %0d want 0 0",
                               obs_idx.size(), done_cyc);
        end
        checks++;
        if (done_csum !== '0) begin
            errors++; $display("FAIL empty_csum got %h want 0", done_csum);
        end
    endtask

    task automatic test_ignore_busy_input();
        logic [N*ELEM_W-1:0] d[2];
        logic [N-1:0]        m[2];
        for (int f = 0; f < 2; f++) begin
            d[f] = rand_data();
            m[f] = N'($urandom_range(1, 1023));
        end
        send_snapshot(d[0], m[0]);
        in_valid = 1'b1;
        in_data  = d[1];
        in_mask  = m[1];
        for (int f = 0; f < 2; f++) begin
            model(d[f], m[f]);
            collect(0);
            checks++;
            if (obs_idx.size() != exp_idx.size()) begin
                errors++; $display("FAIL busy_f%0d_beats got %0d want %0d", f, obs_idx.size(),
                                   exp_idx.size());
            end
            foreach (exp_idx[i]) begin
                if (i < obs_idx.size()) begin
                    checks++;
                    if (obs_idx[i] != exp_idx[i] || obs_data[i] !== exp_data[i]
                        || obs_last[i] !== (i == exp_idx.size() - 1)) begin
                        errors++;
                        $display("FAIL busy_f%0d_beat%0d got idx %0d data %h want idx %0d data %h",
                                 f, i, obs_idx[i], obs_data[i], exp_idx[i], exp_data[i]);
                    end
                end
            end
            checks++;
            if (!got_done || done_csum !== exp_csum || busy_ready != 0) begin
                errors++; $display("FAIL busy_f%0d_done got done %0b csum %h busy_ready %0d want 1 %h 0",
                                   f, got_done, done_csum, busy_ready, exp_csum);
            end
            if (f == 0) begin
                @(negedge clk);
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL busy_reaccept got in_ready %0b want 1", in_ready);
                end
                @(posedge clk);
                #1 in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [N*ELEM_W-1:0] d = rand_data();
        int bad = 0;
        model(d, 10'b01_1011_0001);
        out_ready = 1'b1;
        send_snapshot(d, 10'b01_1011_0001);
        checks++;
        if (out_valid !== 1'b1 || int'(out_idx) != exp_idx[0]) begin
            errors++; $display("FAIL midrst_first got valid %0b idx %0d want 1 %0d", out_valid,
                               out_idx, exp_idx[0]);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_done !== 1'b0) begin
            errors++; $display("FAIL midrst_state got valid %0b ready %0b done %0b want 0 1 0",
                               out_valid, in_ready, frame_done);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid || frame_done) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL midrst_quiet got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_random();
        logic [N*ELEM_W-1:0] d;
        logic [N-1:0]        m;
        for (int f = 0; f < 8; f++) begin
            d = rand_data();
            m = N'($urandom_range(0, 1023));
            model(d, m);
            send_snapshot(d, m);
            collect(2);
            checks++;
            if (obs_idx.size() != exp_idx.size()) begin
                errors++; $display("FAIL rand%0d_beats got %0d want %0d", f, obs_idx.size(),
                                   exp_idx.size());
            end
            foreach (exp_idx[i]) begin
                if (i < obs_idx.size()) begin
                    checks++;
                    if (obs_idx[i] != exp_idx[i] || obs_data[i] !== exp_data[i]
                        || obs_last[i] !== (i == exp_idx.size() - 1)) begin
                        errors++;
                        $display("FAIL rand%0d_beat%0d got idx %0d data %h last %0b want idx %0d data %h",
                                 f, i, obs_idx[i], obs_data[i], obs_last[i], exp_idx[i],
                                 exp_data[i]);
                    end
                end
            end
            checks++;
            if (!got_done || done_csum !== exp_csum || unstable != 0 || busy_ready != 0) begin
                errors++;
                $display("FAIL rand%0d_done got done %0b csum %h unstable %0d busy %0d want 1 %h 0 0",
                         f, got_done, done_csum, unstable, busy_ready, exp_csum);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_sparse_stall();
        test_empty_mask();
        test_ignore_busy_input();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got no finish want finish");
        $fatal(1);
    end

endmodule
